// File: rtl/midi_uart_tx.sv
// rtl/midi_uart_tx.sv - 8N1 MIDI/UART transmitter with a one-byte holding register.
// Optional running-status suppression is enabled by defining MIDI_RUNNING_STATUS_EN.
module midi_uart_tx #(
  parameter int CLKS_PER_BIT = 8,
  parameter int CNT_W        = $clog2(CLKS_PER_BIT)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       midi_out,
  output logic       busy,
  output logic       frame_done
);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

  state_t           r_state, w_state_n;
  logic [7:0]       r_hold, w_hold_n;
  logic             r_hold_full, w_hold_full_n;
  logic [7:0]       r_shift, w_shift_n;
  logic [CNT_W-1:0] r_cnt, w_cnt_n;
  logic [2:0]       r_bit, w_bit_n;
  logic             r_midi_out, w_midi_out_n;
  logic             r_frame_done, w_frame_done_n;

  logic w_accept;
  logic w_period_end;
  logic w_load;
  logic w_drop;

`ifdef MIDI_RUNNING_STATUS_EN
  logic [7:0] r_last_status, w_last_status_n;
  logic       r_status_valid, w_status_valid_n;

  // A channel-voice status byte identical to the current running status is redundant.
  assign w_drop = r_status_valid && (r_hold >= 8'h80) && (r_hold <= 8'hEF) &&
                  (r_hold == r_last_status);
`else
  assign w_drop = 1'b0;
`endif

  assign w_accept     = tx_valid && !r_hold_full;
  assign w_period_end = (r_cnt == LAST_CNT);
  // The shifter can take a new byte while idle or at the very end of a stop bit.
  assign w_load       = r_hold_full &&
                        ((r_state == S_IDLE) || ((r_state == S_STOP) && w_period_end));

  assign tx_ready   = !r_hold_full;
  assign midi_out   = r_midi_out;
  assign busy       = (r_state != S_IDLE) || r_hold_full;
  assign frame_done = r_frame_done;

  always_comb begin
    w_state_n      = r_state;
    w_hold_n       = r_hold;
    w_hold_full_n  = r_hold_full;
    w_shift_n      = r_shift;
    w_cnt_n        = r_cnt;
    w_bit_n        = r_bit;
    w_midi_out_n   = 1'b1;
    w_frame_done_n = 1'b0;
`ifdef MIDI_RUNNING_STATUS_EN
    w_last_status_n  = r_last_status;
    w_status_valid_n = r_status_valid;
`endif

    case (r_state)
      S_IDLE: begin
        w_cnt_n = '0;
      end
      S_START: begin
        if (w_period_end) begin
          w_state_n = S_DATA;
          w_cnt_n   = '0;
          w_bit_n   = 3'd0;
        end else begin
          w_cnt_n = r_cnt + CNT_W'(1);
        end
      end
      S_DATA: begin
        if (w_period_end) begin
          w_cnt_n   = '0;
          w_shift_n = {1'b0, r_shift[7:1]};
          if (r_bit == 3'd7) begin
            w_state_n = S_STOP;
          end else begin
            w_bit_n = r_bit + 3'd1;
          end
        end else begin
          w_cnt_n = r_cnt + CNT_W'(1);
        end
      end
      S_STOP: begin
        if (w_period_end) begin
          w_state_n = S_IDLE;
          w_cnt_n   = '0;
        end else begin
          w_cnt_n = r_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_state_n = S_IDLE;
      end
    endcase

    // A dropped byte leaves the FSM heading to IDLE, so only a real load restarts a frame.
    if (w_load) begin
      w_hold_full_n = 1'b0;
      if (!w_drop) begin
        w_shift_n = r_hold;
        w_state_n = S_START;
        w_cnt_n   = '0;
        w_bit_n   = 3'd0;
`ifdef MIDI_RUNNING_STATUS_EN
        if ((r_hold >= 8'h80) && (r_hold <= 8'hEF)) begin
          w_last_status_n  = r_hold;
          w_status_valid_n = 1'b1;
        end else if ((r_hold >= 8'hF0) && (r_hold <= 8'hF7)) begin
          w_status_valid_n = 1'b0;
        end
`endif
      end
    end

    if (w_accept) begin
      w_hold_n      = tx_data;
      w_hold_full_n = 1'b1;
    end

    // Line and pulse are registered from the current state, so they trail it by one cycle.
    case (r_state)
      S_START: w_midi_out_n = 1'b0;
      S_DATA:  w_midi_out_n = r_shift[0];
      default: w_midi_out_n = 1'b1;
    endcase
    w_frame_done_n = (r_state == S_STOP) && w_period_end;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= S_IDLE;
      r_hold         <= 8'h00;
      r_hold_full    <= 1'b0;
      r_shift        <= 8'h00;
      r_cnt          <= '0;
      r_bit          <= 3'd0;
      r_midi_out     <= 1'b1;
      r_frame_done   <= 1'b0;
`ifdef MIDI_RUNNING_STATUS_EN
      r_last_status  <= 8'h00;
      r_status_valid <= 1'b0;
`endif
    end else begin
      r_state        <= w_state_n;
      r_hold         <= w_hold_n;
      r_hold_full    <= w_hold_full_n;
      r_shift        <= w_shift_n;
      r_cnt          <= w_cnt_n;
      r_bit          <= w_bit_n;
      r_midi_out     <= w_midi_out_n;
      r_frame_done   <= w_frame_done_n;
`ifdef MIDI_RUNNING_STATUS_EN
      r_last_status  <= w_last_status_n;
      r_status_valid <= w_status_valid_n;
`endif
    end
  end

endmodule

// File: tb/tb_midi_uart_tx.sv
// tb/tb_midi_uart_tx.sv - self-checking bench for midi_uart_tx at CLKS_PER_BIT 8, 2 and 16.
module tb_midi_uart_tx;
  localparam int MAXC = 8192;
  typedef logic [7:0] bq_t[$];

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] tv;
  logic [7:0] td [3];
  logic [2:0] mo, rdy, bsy, fd;

  logic [2:0] lmo  [MAXC];
  logic [2:0] lrdy [MAXC];
  logic [2:0] lbsy [MAXC];
  logic [2:0] lfd  [MAXC];

  int cyc = 0;
  int total = 0;
  int bad = 0;
  int acc[$];
  bq_t dec;

  always #5 clk = ~clk;

  midi_uart_tx #(.CLKS_PER_BIT(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .tx_data(td[0]), .tx_valid(tv[0]), .tx_ready(rdy[0]),
    .midi_out(mo[0]), .busy(bsy[0]), .frame_done(fd[0]));
  midi_uart_tx #(.CLKS_PER_BIT(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .tx_data(td[1]), .tx_valid(tv[1]), .tx_ready(rdy[1]),
    .midi_out(mo[1]), .busy(bsy[1]), .frame_done(fd[1]));
  midi_uart_tx #(.CLKS_PER_BIT(16)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .tx_data(td[2]), .tx_valid(tv[2]), .tx_ready(rdy[2]),
    .midi_out(mo[2]), .busy(bsy[2]), .frame_done(fd[2]));

  // Sample index c holds the outputs just after the c-th rising edge.
  always @(posedge clk) begin
    #2;
    if (cyc < MAXC) begin
      lmo[cyc]  = mo;
      lrdy[cyc] = rdy;
      lbsy[cyc] = bsy;
      lfd[cyc]  = fd;
    end
    cyc = cyc + 1;
  end

  function automatic int nper(input int s);
    return (s == 0) ? 8 : (s == 1) ? 2 : 16;
  endfunction

  // Bytes that should appear on the line, from the running-status rules.
  function automatic bq_t filt(input bq_t q);
    bq_t r;
    logic [7:0] last;
    bit valid;
    last = 8'h00;
    valid = 1'b0;
    foreach (q[i]) begin
`ifdef MIDI_RUNNING_STATUS_EN
      if (q[i] >= 8'h80 && q[i] <= 8'hEF) begin
        if (!(valid && last == q[i])) begin
          r.push_back(q[i]);
          last = q[i];
          valid = 1'b1;
        end
      end else if (q[i] >= 8'hF0 && q[i] <= 8'hF7) begin
        r.push_back(q[i]);
        valid = 1'b0;
      end else begin
        r.push_back(q[i]);
      end
`else
      r.push_back(q[i]);
`endif
    end
    return r;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    tv = 3'b000;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_until(input int tgt);
    int guard;
    guard = 0;
    while (cyc < tgt && guard < 4000) begin
      @(negedge clk);
      guard++;
    end
  endtask

  // Keeps tx_valid high; optionally scrambles tx_data whenever tx_ready is low.
  task automatic drive(input int s, input bq_t q, input bit junk);
    int i;
    int guard;
    i = 0;
    guard = 0;
    acc.delete();
    while (i < q.size() && guard < 3000) begin
      @(negedge clk);
      tv[s] = 1'b1;
      td[s] = (junk && !rdy[s]) ? 8'($urandom) : q[i];
      if (rdy[s]) begin
        acc.push_back(cyc);
        i++;
      end
      guard++;
    end
    @(negedge clk);
    tv[s] = 1'b0;
    td[s] = 8'($urandom);
    if (i < q.size()) begin
      total++;
      bad++;
      $display("FAIL drive_timeout dut=%0d accepted=%0d required=%0d", s, i, q.size());
      while (acc.size() < q.size()) acc.push_back(cyc);
    end
  endtask

  // Exact per-cycle comparison of contiguous frames starting at sample st.
  task automatic check_frames(input int s, input int st, input bq_t q, input string nm);
    int n;
    int badi;
    int idx;
    logic el;
    logic ef;
    logic gl;
    logic gf;
    logic xl;
    logic xf;
    n = nper(s);
    total++;
    if (lmo[st-1][s] !== 1'b1) begin
      bad++;
      $display("FAIL %s_idle_before cycle=%0d line=%b required=1", nm, st - 1, lmo[st-1][s]);
    end
    for (int j = 0; j < q.size(); j++) begin
      badi = -1;
      gl = 1'b0; gf = 1'b0; xl = 1'b0; xf = 1'b0;
      for (int b = 0; b < 10; b++) begin
        for (int t = 0; t < n; t++) begin
          idx = st + 10 * n * j + n * b + t;
          el = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : q[j][b-1];
          ef = (b == 9 && t == n - 1);
          if (badi < 0 && (lmo[idx][s] !== el || lfd[idx][s] !== ef)) begin
            badi = idx;
            gl = lmo[idx][s]; gf = lfd[idx][s]; xl = el; xf = ef;
          end
        end
      end
      total++;
      if (badi >= 0) begin
        bad++;
        $display("FAIL %s frame=%0d byte=%02h cycle=%0d line=%b frame_done=%b required line=%b frame_done=%b",
                 nm, j, q[j], badi, gl, gf, xl, xf);
      end
    end
  endtask

  task automatic decode(input int s, input int a, input int b);
    int n;
    int i;
    logic [7:0] v;
    n = nper(s);
    dec.delete();
    i = a;
    while (i < b) begin
      if (lmo[i][s] === 1'b0) begin
        for (int k = 0; k < 8; k++) v[k] = lmo[i + n * (k + 1) + n / 2][s];
        dec.push_back(v);
        i += 10 * n;
      end else begin
        i++;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if (mo !== 3'b111) begin bad++; $display("FAIL reset_midi_out got=%b required=111", mo); end
    total++;
    if (rdy !== 3'b111) begin bad++; $display("FAIL reset_tx_ready got=%b required=111", rdy); end
    total++;
    if (bsy !== 3'b000) begin bad++; $display("FAIL reset_busy got=%b required=000", bsy); end
    total++;
    if (fd !== 3'b000) begin bad++; $display("FAIL reset_frame_done got=%b required=000", fd); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single();
    bq_t q;
    int k;
    q = '{8'h3E};
    drive(0, q, 1'b0);
    k = acc[0];
    wait_until(k + 2 + 80 + 4);
    total++;
    if (lrdy[k][0] !== 1'b0 || lrdy[k+1][0] !== 1'b1) begin
      bad++;
      $display("FAIL single_ready accept=%b after_load=%b required 0,1", lrdy[k][0], lrdy[k+1][0]);
    end
    total++;
    if (lbsy[k][0] !== 1'b1 || lbsy[k+81][0] !== 1'b0) begin
      bad++;
      $display("FAIL single_busy accept=%b after_frame=%b required 1,0", lbsy[k][0], lbsy[k+81][0]);
    end
    check_frames(0, k + 2, q, "single_3e");
  endtask

  task automatic test_back_to_back();
    bq_t q;
    int k;
    q = '{8'h90, 8'h40, 8'h7F};
    drive(0, q, 1'b0);
    k = acc[0];
    wait_until(k + 2 + 240 + 4);
    total++;
    if (acc[1] !== k + 2 || acc[2] !== k + 82) begin
      bad++;
      $display("FAIL b2b_accept_cycles got=%0d,%0d required=%0d,%0d", acc[1], acc[2], k + 2, k + 82);
    end
    for (int j = 0; j < 3; j++) begin
      total++;
      if (lrdy[k+1+80*j][0] !== 1'b1 || lrdy[k+80*j][0] !== 1'b0) begin
        bad++;
        $display("FAIL b2b_ready frame=%0d before_load=%b after_load=%b required 0,1",
                 j, lrdy[k+80*j][0], lrdy[k+1+80*j][0]);
      end
    end
    check_frames(0, k + 2, q, "b2b");
  endtask

  task automatic test_reset_mid();
    bq_t q;
    int k;
    int tgt;
    int errs;
    q = '{8'h80};
    drive(0, q, 1'b0);
    k = acc[0];
    tgt = k + 2 + 4 * 8 + 4;
    wait_until(tgt);
    rst_n = 1'b0;
    #1;
    total++;
    if (mo[0] !== 1'b1 || rdy[0] !== 1'b1 || bsy[0] !== 1'b0 || fd[0] !== 1'b0) begin
      bad++;
      $display("FAIL midreset_outputs line=%b ready=%b busy=%b frame_done=%b required 1,1,0,0",
               mo[0], rdy[0], bsy[0], fd[0]);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    wait_until(tgt + 100);
    errs = 0;
    for (int i = tgt; i < tgt + 100; i++) begin
      if (lmo[i][0] !== 1'b1 || lfd[i][0] !== 1'b0) errs++;
    end
    total++;
    if (errs != 0) begin
      bad++;
      $display("FAIL midreset_quiet bad_cycles=%0d required=0", errs);
    end
    q = '{8'h55};
    drive(0, q, 1'b0);
    k = acc[0];
    wait_until(k + 2 + 80 + 4);
    check_frames(0, k + 2, q, "after_reset_55");
  endtask

  task automatic test_hold_full();
    bq_t q;
    int k;
    int errs;
    q = '{8'h12, 8'h34, 8'hA5};
    drive(0, q, 1'b1);
    k = acc[0];
    wait_until(k + 2 + 240 + 4);
    total++;
    if (acc[2] !== k + 82) begin
      bad++;
      $display("FAIL hold_a5_accept got=%0d required=%0d", acc[2], k + 82);
    end
    errs = 0;
    for (int i = k + 2; i <= k + 80; i++) if (lrdy[i][0] !== 1'b0) errs++;
    total++;
    if (errs != 0) begin
      bad++;
      $display("FAIL hold_ready_low bad_cycles=%0d required=0", errs);
    end
    check_frames(0, k + 2, q, "hold_full");
  endtask

  task automatic test_random();
    bq_t q;
    int k;
    int tries;
    do_reset();
    tries = 0;
    do begin
      q.delete();
      for (int i = 0; i < 5; i++) q.push_back(8'($urandom));
      tries++;
    end while (filt(q).size() != q.size() && tries < 50);
    if (filt(q).size() == q.size()) begin
      drive(0, q, 1'b1);
      k = acc[0];
      wait_until(k + 2 + 400 + 4);
      check_frames(0, k + 2, q, "random");
    end
  endtask

  task automatic test_running_status();
    bq_t q;
    bq_t e;
    int k;
    int pulses;
    do_reset();
    q = '{8'h90, 8'h3C, 8'h40, 8'h90, 8'h3E, 8'h40, 8'hF8, 8'h90};
    e = filt(q);
    drive(0, q, 1'b0);
    k = acc[0];
    wait_until(k + 2 + 80 * q.size() + 20);
    decode(0, k, k + 2 + 80 * q.size() + 10);
    total++;
    if (dec.size() != e.size()) begin
      bad++;
      $display("FAIL rs_frame_count got=%0d required=%0d", dec.size(), e.size());
    end
    for (int i = 0; i < e.size() && i < dec.size(); i++) begin
      total++;
      if (dec[i] !== e[i]) begin
        bad++;
        $display("FAIL rs_byte idx=%0d got=%02h required=%02h", i, dec[i], e[i]);
      end
    end
    pulses = 0;
    for (int i = k; i < k + 2 + 80 * q.size() + 10; i++) if (lfd[i][0] === 1'b1) pulses++;
    total++;
    if (pulses != e.size()) begin
      bad++;
      $display("FAIL rs_frame_done_count got=%0d required=%0d", pulses, e.size());
    end
  endtask

  task automatic test_sweep();
    bq_t q;
    int k;
    q = '{8'hFF, 8'h00};
    for (int s = 1; s <= 2; s++) begin
      drive(s, q, 1'b0);
      k = acc[0];
      wait_until(k + 2 + 20 * nper(s) + 4);
      check_frames(s, k + 2, q, (s == 1) ? "sweep2" : "sweep16");
      total++;
      if (lmo[k+2+20*nper(s)][s] !== 1'b1 || lbsy[k+2+20*nper(s)][s] !== 1'b0) begin
        bad++;
        $display("FAIL sweep_idle_after dut=%0d line=%b busy=%b required 1,0",
                 s, lmo[k+2+20*nper(s)][s], lbsy[k+2+20*nper(s)][s]);
      end
    end
  endtask

  initial begin
    tv = 3'b000;
    for (int s = 0; s < 3; s++) td[s] = 8'h00;
    test_reset();
    test_single();
    test_back_to_back();
    test_reset_mid();
    test_hold_full();
    test_random();
    test_running_status();
    test_sweep();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
